jtoutrun_bank_arb: RTL and testbench
====================================

JTOUTRUN_BANK_ARB -- requirements
Module: jtoutrun_bank_arb

Interface
REQ-001 SHALL have parameter N, default 4: number of ROM clients, legal 2..8.
REQ-002 SHALL have parameter AW, default 22: client and bank address width.
REQ-003 SHALL have parameter DW, default 16: data width, 16 or 32; 32 SHALL take two consecutive bank words.
REQ-004 SHALL have parameter PRIO, default 0: 0 = round-robin grant, 1 = fixed priority with client 0 highest.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port cs, input, N: per-client request.
REQ-008 SHALL have port addr, input, N*AW: per-client word address; client k uses slice k.
REQ-009 SHALL have port ok, output, N: per-client data valid.
REQ-010 SHALL have port dout, output, N*DW: per-client data.
REQ-011 SHALL have port ba_addr, output, AW: bank address.
REQ-012 SHALL have port ba_rd, output, 1: bank read request.
REQ-013 SHALL have port ba_ack, input, 1: request accepted.
REQ-014 SHALL have port ba_dst, input, 1: first data word strobe.
REQ-015 SHALL have port ba_rdy, input, 1: burst complete.
REQ-016 SHALL have port data_read, input, 16: SDRAM read data.

Function
REQ-017 SHALL keep one cache entry per client: tag (AW bits), data (DW bits), valid flag.
REQ-018 SHALL assert ok[k] = cs[k] & valid[k] & (tag[k] == addr[k]), registered with 1-cycle latency on a hit.
REQ-019 SHALL drive dout[k] = data[k] at all times; dout SHALL only be meaningful while ok[k]=1.
REQ-020 SHALL treat client k as missing when cs[k]=1 and ok-condition is false; only missing clients SHALL compete for the bank.
REQ-021 SHALL run an FSM with states IDLE, REQ, WAIT (DW=16) and IDLE, REQ, WAIT, WORD2 (DW=32).
REQ-022 IDLE: if any client misses, grant one, latch its addr into ba_addr, set ba_rd=1, go to REQ; otherwise stay in IDLE with ba_rd=0.
REQ-023 REQ: hold ba_rd and ba_addr stable until ba_ack=1, then clear ba_rd and go to WAIT.
REQ-024 WAIT: on ba_dst capture data_read into the low 16 bits of the granted entry; for DW=32 go to WORD2, which captures the next cycle's data_read into the high 16 bits.
REQ-025 On ba_rdy: write tag = latched address, set valid, go to IDLE; ok for that client SHALL rise on the following cycle if addr is unchanged.
REQ-026 Round-robin (PRIO=0): search starts at last grant + 1 modulo N; a continuously missing client SHALL be granted within N bank transactions.
REQ-027 Fixed priority (PRIO=1): lowest-index missing client SHALL win.
REQ-028 If a client changes addr or drops cs while its transaction is in flight, the transaction SHALL complete and fill its entry with the old address; the new address SHALL then miss and request again.
REQ-029 Grant, ba_addr and the FSM SHALL NOT change between ba_rd rising and ba_rdy.
REQ-030 ba_ack and ba_rdy in the same cycle SHALL be accepted: data captured, entry filled, return to IDLE.
REQ-031 ba_dst or ba_rdy received in IDLE SHALL be ignored.
REQ-032 Address compare SHALL use the full AW bits, with no wrap or aliasing.

Reset
REQ-033 While rst_n=0: all valid cleared; ok=0; ba_rd=0; ba_addr=0; FSM=IDLE; round-robin pointer=N-1, so client 0 is searched first.
REQ-034 Reset asserted mid-transaction SHALL abort immediately with no entry written; after release the arbiter SHALL accept a new request from IDLE.

Verification
REQ-035 Single miss, N=4, DW=16: cs[2]=1, addr=0x1234; the bank acks after 3 cycles, dst with data 0xBEEF, then rdy. Required: ba_addr=0x1234, ok[2]=1 the cycle after rdy, dout slice 2=0xBEEF, and no further ba_rd while the address is held.
REQ-036 Round-robin: all four clients miss continuously. Required: grant order 0,1,2,3,0 and no client waits more than 4 transactions.
REQ-037 PRIO=1: clients 1 and 3 miss together. Required: client 1 is served first and client 3 is served next.
REQ-038 DW=32: words 0x1111 then 0x2222 are delivered. Required: dout=0x22221111 and ok rises the cycle after rdy.
REQ-039 Address change in flight: client 0 switches addr 0x10 to 0x20 after ack. Required: the entry fills with tag 0x10, ok stays 0, and a second request goes out with ba_addr=0x20.
REQ-040 Reset pulse during WAIT. Required: ok=0 and ba_rd=0 immediately; after release, a fresh request for the same address is reissued.

Source files
------------

// File: rtl/jtoutrun_bank_arb.sv
// Multi-client ROM arbiter for one SDRAM bank: one tag/data cache entry per client,
// misses compete for the bank and fill their entry on burst completion.
module jtoutrun_bank_arb #(
    parameter int unsigned N    = 4,
    parameter int unsigned AW   = 22,
    parameter int unsigned DW   = 16,
    parameter int unsigned PRIO = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    cs,
    input  logic [N*AW-1:0] addr,
    output logic [N-1:0]    ok,
    output logic [N*DW-1:0] dout,
    output logic [AW-1:0]   ba_addr,
    output logic            ba_rd,
    input  logic            ba_ack,
    input  logic            ba_dst,
    input  logic            ba_rdy,
    input  logic [15:0]     data_read
);
    localparam int unsigned GW   = $clog2(N);
    localparam bit          WIDE = (DW > 16);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StWord2} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] tag_q  [N];
    logic [DW-1:0] data_q [N];
    logic [N-1:0]  valid_q;
    logic [N-1:0]  ok_q, ok_d;
    logic [N-1:0]  hit, fill_hit, miss;
    logic [AW-1:0] ba_addr_q;
    logic [GW-1:0] gnt_q, last_q, pick, idx;
    logic [AW-1:0] pick_addr;
    logic          pick_vld;
    logic [DW-1:0] buf_q, buf_d;
    logic          hi_done_q;
    logic          start, fill, cap_lo, cap_hi;

    // Hit detection; the fill bypass lets ok rise the cycle right after ba_rdy.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            hit[k]      = cs[k] & valid_q[k] & (tag_q[k] == addr[k*AW +: AW]);
            fill_hit[k] = cs[k] & fill & (gnt_q == GW'(k)) & (addr[k*AW +: AW] == ba_addr_q);
        end
        miss = cs & ~hit;
        ok_d = hit | fill_hit;
    end

    // Lowest-numbered pass wins, so iterate from the lowest-priority candidate down.
    always_comb begin
        pick      = '0;
        pick_vld  = 1'b0;
        idx       = '0;
        pick_addr = '0;
        for (int unsigned i = N; i >= 1; i--) begin
            if (PRIO != 0) begin
                idx = GW'(i - 1);
            end else begin
                idx = GW'((32'(last_q) + i) % N);
            end
            if (miss[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (pick == GW'(k)) begin
                pick_addr = addr[k*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ba_ack) begin
                    if (fill) begin
                        state_d = StIdle;
                    end else if (cap_lo && WIDE) begin
                        state_d = StWord2;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (fill) begin
                    state_d = StIdle;
                end else if (cap_lo && WIDE) begin
                    state_d = StWord2;
                end
            end
            StWord2: begin
                if (fill) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ba_rd   = (state_q == StReq);
        ba_addr = ba_addr_q;
        ok      = ok_q;
        start   = (state_q == StIdle) && pick_vld;
        cap_lo  = (((state_q == StReq) && ba_ack) || (state_q == StWait)) && ba_dst;
        cap_hi  = WIDE && (state_q == StWord2) && !hi_done_q;
        fill    = (((state_q == StReq) && ba_ack) || (state_q == StWait) ||
                   (state_q == StWord2)) && ba_rdy;
        for (int k = 0; k < N; k++) begin
            dout[k*DW +: DW] = data_q[k];
        end
    end

    // Burst data collects here and only reaches the cache on fill, so an aborted
    // or redirected transaction never disturbs a live entry.
    always_comb begin
        buf_d = buf_q;
        if (cap_lo) begin
            buf_d[15:0] = data_read;
        end
        if (cap_hi) begin
            buf_d[DW-1:DW-16] = data_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            ok_q      <= '0;
            ba_addr_q <= '0;
            gnt_q     <= '0;
            last_q    <= GW'(N - 1);
            buf_q     <= '0;
            hi_done_q <= 1'b0;
        end else begin
            ok_q      <= ok_d;
            buf_q     <= buf_d;
            hi_done_q <= (state_q == StWord2);
            if (start) begin
                gnt_q     <= pick;
                last_q    <= pick;
                ba_addr_q <= pick_addr;
            end
            if (fill) begin
                valid_q[gnt_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[gnt_q]  <= ba_addr_q;
            data_q[gnt_q] <= buf_d;
        end
    end

endmodule

// File: tb/tb_jtoutrun_bank_arb.sv
// Scoreboard bench: three arbiter flavours share one bank model; expected bank
// requests and ok rises are queued by the stimulus and checked by a monitor.
module tb_jtoutrun_bank_arb;
    localparam int N  = 4;
    localparam int AW = 22;

    typedef struct {
        int          dut;
        int          cl;
        logic [31:0] data;
        bit          lat;
    } ok_exp_t;

    typedef struct {
        int          dut;
        logic [21:0] a;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ba_ack = 1'b0, ba_dst = 1'b0, ba_rdy = 1'b0;
    logic [15:0] data_read = '0;

    logic [N-1:0]    cs_rr = '0, cs_fp = '0, cs_w = '0;
    logic [N*AW-1:0] addr_rr = '0, addr_fp = '0, addr_w = '0;
    logic [N-1:0]    ok_rr, ok_fp, ok_w;
    logic [N*16-1:0] dout_rr, dout_fp;
    logic [N*32-1:0] dout_w;
    logic [AW-1:0]   ba_addr_rr, ba_addr_fp, ba_addr_w;
    logic            rd_rr, rd_fp, rd_w;

    jtoutrun_bank_arb #(.N(N), .AW(AW), .DW(16), .PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .cs(cs_rr), .addr(addr_rr), .ok(ok_rr), .dout(dout_rr),
        .ba_addr(ba_addr_rr), .ba_rd(rd_rr), .ba_ack(ba_ack), .ba_dst(ba_dst),
        .ba_rdy(ba_rdy), .data_read(data_read)
    );

    jtoutrun_bank_arb #(.N(N), .AW(AW), .DW(16), .PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .cs(cs_fp), .addr(addr_fp), .ok(ok_fp), .dout(dout_fp),
        .ba_addr(ba_addr_fp), .ba_rd(rd_fp), .ba_ack(ba_ack), .ba_dst(ba_dst),
        .ba_rdy(ba_rdy), .data_read(data_read)
    );

    jtoutrun_bank_arb #(.N(N), .AW(AW), .DW(32), .PRIO(0)) u_w32 (
        .clk(clk), .rst_n(rst_n), .cs(cs_w), .addr(addr_w), .ok(ok_w), .dout(dout_w),
        .ba_addr(ba_addr_w), .ba_rd(rd_w), .ba_ack(ba_ack), .ba_dst(ba_dst),
        .ba_rdy(ba_rdy), .data_read(data_read)
    );

    ok_exp_t ok_q[$];
    rd_exp_t rd_q[$];
    int      total = 0;
    int      bad = 0;
    int      sel = 0;
    bit      done = 1'b0;

    task automatic exp_rd(input int d, input logic [21:0] a);
        rd_exp_t e;
        e.dut = d;
        e.a   = a;
        rd_q.push_back(e);
    endtask

    task automatic exp_ok(input int d, input int c, input logic [31:0] v, input bit lat);
        ok_exp_t e;
        e.dut  = d;
        e.cl   = c;
        e.data = v;
        e.lat  = lat;
        ok_q.push_back(e);
    endtask

    task automatic set_addr(input int d, input int c, input logic [21:0] a);
        case (d)
            0:       addr_rr[c*AW +: AW] = a;
            1:       addr_fp[c*AW +: AW] = a;
            default: addr_w[c*AW +: AW]  = a;
        endcase
    endtask

    function automatic logic cur_rd();
        case (sel)
            0:       return rd_rr;
            1:       return rd_fp;
            default: return rd_w;
        endcase
    endfunction

    task automatic wait_rd();
        int t = 0;
        while (!cur_rd()) begin
            if (t == 200) begin
                $display("FAIL ba_rd_timeout dut%0d: got ba_rd=0, required 1 within 200 cycles",
                         sel);
                $fatal(1, "bank request never arrived");
            end
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic bank_txn(input int dly, input logic [15:0] w0, input logic [15:0] w1,
                            input bit two, input bit chg, input logic [21:0] chg_a);
        wait_rd();
        repeat (dly) @(posedge clk);
        #1;
        ba_ack = 1'b1;
        @(posedge clk);
        #1;
        ba_ack = 1'b0;
        if (chg) set_addr(0, 0, chg_a);
        ba_dst    = 1'b1;
        data_read = w0;
        @(posedge clk);
        #1;
        ba_dst = 1'b0;
        if (two) begin
            data_read = w1;
            @(posedge clk);
            #1;
        end
        ba_rdy = 1'b1;
        @(posedge clk);
        #1;
        ba_rdy    = 1'b0;
        data_read = '0;
    endtask

    // ack, dst and rdy all in the cycle the request is seen
    task automatic bank_fast(input logic [15:0] w);
        wait_rd();
        ba_ack    = 1'b1;
        ba_dst    = 1'b1;
        ba_rdy    = 1'b1;
        data_read = w;
        @(posedge clk);
        #1;
        ba_ack    = 1'b0;
        ba_dst    = 1'b0;
        ba_rdy    = 1'b0;
        data_read = '0;
    endtask

    logic [3:0] okp [3] = '{default: '0};
    logic       rdp [3] = '{default: 1'b0};
    int         cyc = 0;
    int         rdy_cyc = -10;

    always @(negedge clk) begin
        logic [3:0]  okv;
        logic        rdv;
        logic [21:0] av;
        logic [31:0] dv;
        ok_exp_t     e;
        rd_exp_t     r;
        for (int d = 0; d < 3; d++) begin
            case (d)
                0:       begin okv = ok_rr; rdv = rd_rr; av = ba_addr_rr; end
                1:       begin okv = ok_fp; rdv = rd_fp; av = ba_addr_fp; end
                default: begin okv = ok_w;  rdv = rd_w;  av = ba_addr_w;  end
            endcase
            if (!rst_n) begin
                total++;
                if (okv != '0 || rdv != 1'b0 || av != '0) begin
                    bad++;
                    $display("FAIL reset_state dut%0d: got ok=%b ba_rd=%b ba_addr=%h, required 0",
                             d, okv, rdv, av);
                end
            end
            if (rdv && !rdp[d]) begin
                total++;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ba_rd dut%0d: got ba_addr=%h, required no request",
                             d, av);
                end else begin
                    r = rd_q.pop_front();
                    if (r.dut != d || r.a != av) begin
                        bad++;
                        $display("FAIL ba_addr dut%0d: got %h, required dut%0d addr %h",
                                 d, av, r.dut, r.a);
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (okv[k] && !okp[d][k]) begin
                    case (d)
                        0:       dv = {16'h0, dout_rr[k*16 +: 16]};
                        1:       dv = {16'h0, dout_fp[k*16 +: 16]};
                        default: dv = dout_w[k*32 +: 32];
                    endcase
                    total++;
                    if (ok_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_ok dut%0d: got ok[%0d]=1 dout=%h, required 0",
                                 d, k, dv);
                    end else begin
                        e = ok_q.pop_front();
                        if (e.dut != d || e.cl != k || e.data != dv) begin
                            bad++;
                            $display("FAIL ok_rise dut%0d: got client=%0d dout=%h, required dut%0d client=%0d dout=%h",
                                     d, k, dv, e.dut, e.cl, e.data);
                        end
                        if (e.lat) begin
                            total++;
                            if (cyc != rdy_cyc + 1) begin
                                bad++;
                                $display("FAIL ok_latency dut%0d client%0d: got %0d cycles after rdy, required 1",
                                         d, k, cyc - rdy_cyc);
                            end
                        end
                    end
                end
            end
            okp[d] = okv;
            rdp[d] = rdv;
        end
        if (ba_rdy) rdy_cyc = cyc;
        cyc++;
        if (done) begin
            total++;
            if (ok_q.size() != 0 || rd_q.size() != 0) begin
                bad++;
                $display("FAIL leftover: got %0d ok and %0d ba_rd still expected, required 0 and 0",
                         ok_q.size(), rd_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single miss, then a plain hit after cs is re-raised
        sel = 0;
        exp_rd(0, 22'h1234);
        exp_ok(0, 2, 32'h0000_BEEF, 1'b1);
        cs_rr[2] = 1'b1;
        set_addr(0, 2, 22'h1234);
        bank_txn(3, 16'hBEEF, 16'h0, 1'b0, 1'b0, 22'h0);
        repeat (10) @(posedge clk);
        #1;
        cs_rr[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_ok(0, 2, 32'h0000_BEEF, 1'b0);
        cs_rr[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cs_rr = '0;

        // ack+dst+rdy together, then an address differing only in the MSB
        exp_rd(0, 22'h3ABCDE);
        exp_ok(0, 3, 32'h0000_CAFE, 1'b1);
        cs_rr[3] = 1'b1;
        set_addr(0, 3, 22'h3ABCDE);
        bank_fast(16'hCAFE);
        repeat (2) @(posedge clk);
        #1;
        exp_rd(0, 22'h1ABCDE);
        exp_ok(0, 3, 32'h0000_0F0F, 1'b1);
        set_addr(0, 3, 22'h1ABCDE);
        bank_txn(1, 16'h0F0F, 16'h0, 1'b0, 1'b0, 22'h0);
        repeat (2) @(posedge clk);
        #1;
        cs_rr = '0;

        // Round-robin: last grant was 3, so order is 0,1,2,3 then 0 again
        for (int c = 0; c < 4; c++) begin
            exp_rd(0, 22'h100 + 22'(c));
            exp_ok(0, c, 32'h0000_A000 + 32'(c), 1'b1);
            set_addr(0, c, 22'h100 + 22'(c));
        end
        exp_rd(0, 22'h200);
        exp_ok(0, 0, 32'h0000_A004, 1'b1);
        cs_rr = 4'hF;
        bank_txn(1, 16'hA000, 16'h0, 1'b0, 1'b0, 22'h0);
        @(posedge clk);
        #1;
        set_addr(0, 0, 22'h200);
        for (int t = 1; t < 5; t++) begin
            bank_txn(1, 16'hA000 + 16'(t), 16'h0, 1'b0, 1'b0, 22'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        cs_rr = '0;

        // Fixed priority: after client 2, round-robin would pick 3; fixed picks 1
        sel = 1;
        exp_rd(1, 22'h32);
        exp_ok(1, 2, 32'h0000_3232, 1'b1);
        cs_fp[2] = 1'b1;
        set_addr(1, 2, 22'h32);
        bank_txn(1, 16'h3232, 16'h0, 1'b0, 1'b0, 22'h0);
        repeat (2) @(posedge clk);
        #1;
        exp_rd(1, 22'h31);
        exp_ok(1, 1, 32'h0000_3131, 1'b1);
        exp_rd(1, 22'h33);
        exp_ok(1, 3, 32'h0000_3333, 1'b1);
        set_addr(1, 1, 22'h31);
        set_addr(1, 3, 22'h33);
        cs_fp = 4'b1110;
        bank_txn(2, 16'h3131, 16'h0, 1'b0, 1'b0, 22'h0);
        bank_txn(0, 16'h3333, 16'h0, 1'b0, 1'b0, 22'h0);
        repeat (2) @(posedge clk);
        #1;
        cs_fp = '0;

        // 32-bit data from two bank words
        sel = 2;
        exp_rd(2, 22'h40);
        exp_ok(2, 0, 32'h2222_1111, 1'b1);
        cs_w[0] = 1'b1;
        set_addr(2, 0, 22'h40);
        bank_txn(2, 16'h1111, 16'h2222, 1'b1, 1'b0, 22'h0);
        repeat (2) @(posedge clk);
        #1;
        cs_w = '0;

        // Address changes after ack: old fill must not raise ok, new address re-requests
        sel = 0;
        exp_rd(0, 22'h10);
        exp_rd(0, 22'h20);
        exp_ok(0, 0, 32'h0000_5555, 1'b1);
        set_addr(0, 0, 22'h10);
        cs_rr[0] = 1'b1;
        bank_txn(1, 16'hAAAA, 16'h0, 1'b0, 1'b1, 22'h20);
        bank_txn(1, 16'h5555, 16'h0, 1'b0, 1'b0, 22'h0);
        repeat (2) @(posedge clk);
        #1;
        cs_rr = '0;

        // Reset in WAIT aborts; same address is requested again afterwards
        exp_rd(0, 22'h55);
        exp_rd(0, 22'h55);
        exp_ok(0, 1, 32'h0000_7777, 1'b1);
        set_addr(0, 1, 22'h55);
        cs_rr[1] = 1'b1;
        wait_rd();
        ba_ack = 1'b1;
        @(posedge clk);
        #1;
        ba_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bank_txn(1, 16'h7777, 16'h0, 1'b0, 1'b0, 22'h0);
        repeat (3) @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
